bus_rr_arbiter: RTL and testbench

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

---
 rtl/bus_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_bus_rr_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter that connects NrHosts requesters to one shared device.
// Only one transaction can be outstanding at a time. The grant is combinational
// in IDLE. The response is steered back to the granted owner. A silent device
// is timed out with an error response.
module bus_rr_arbiter #(
    parameter int NrHosts       = 3,
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      host_req_i    [NrHosts],
    output logic                      host_gnt_o    [NrHosts],
    input  logic [AddressWidth-1:0]   host_addr_i   [NrHosts],
    input  logic                      host_we_i     [NrHosts],
    input  logic [DataWidth/8-1:0]    host_be_i     [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i  [NrHosts],
    output logic                      host_rvalid_o [NrHosts],
    output logic [DataWidth-1:0]      host_rdata_o  [NrHosts],
    output logic                      host_err_o    [NrHosts],
    output logic                      dev_req_o,
    output logic [AddressWidth-1:0]   dev_addr_o,
    output logic                      dev_we_o,
    output logic [DataWidth/8-1:0]    dev_be_o,
    output logic [DataWidth-1:0]      dev_wdata_o,
    input  logic                      dev_rvalid_i,
    input  logic [DataWidth-1:0]      dev_rdata_i,
    input  logic                      dev_err_i
);

    localparam int IdxW = $clog2(NrHosts);
    localparam int CntW = $clog2(TimeoutCycles);

    typedef enum logic {IDLE, WAIT_RSP} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   last_q, last_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              any_req;
    logic [IdxW-1:0]   winner;
    int                cand;
    logic              grant;
    logic              in_wait;
    logic              timeout;
    logic              rsp;

    // Pick the first requester found searching upward from the host after last_q.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        cand    = 0;
        for (int k = 1; k <= NrHosts; k++) begin
            cand = (int'(last_q) + k) % NrHosts;
            if (!any_req && host_req_i[cand]) begin
                any_req = 1'b1;
                winner  = IdxW'(cand);
            end
        end
    end

    // All outputs are gated by rst_ni so that they read zero while reset is held.
    assign grant   = rst_ni && (state_q == IDLE) && any_req;
    assign in_wait = rst_ni && (state_q == WAIT_RSP);
    assign timeout = (cnt_q == CntW'(TimeoutCycles - 1));
    // A real response takes priority over a timeout in the same cycle.
    assign rsp     = in_wait && (dev_rvalid_i || timeout);

    assign dev_req_o   = grant;
    assign dev_addr_o  = grant ? host_addr_i[winner]  : '0;
    assign dev_we_o    = grant ? host_we_i[winner]    : 1'b0;
    assign dev_be_o    = grant ? host_be_i[winner]    : '0;
    assign dev_wdata_o = grant ? host_wdata_i[winner] : '0;

    for (genvar gi = 0; gi < NrHosts; gi++) begin : g_host
        logic sel;
        assign sel               = rsp && (owner_q == IdxW'(gi));
        assign host_gnt_o[gi]    = grant && (winner == IdxW'(gi));
        assign host_rvalid_o[gi] = sel;
        // When the timeout fires, rdata is zero and err is forced high.
        assign host_rdata_o[gi]  = (sel && dev_rvalid_i) ? dev_rdata_i : '0;
        assign host_err_o[gi]    = sel && (dev_rvalid_i ? dev_err_i : 1'b1);
    end

    // Next-state logic: grant in IDLE, then wait for a response or the timeout.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    last_d  = winner;
                    owner_d = winner;
                    cnt_d   = '0;
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (dev_rvalid_i || timeout) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers. Reset points last_q at the top host so that host 0 wins first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= IdxW'(NrHosts - 1);
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter with 3 hosts, 32-bit buses and a 16-cycle timeout.
module tb_bus_rr_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 32;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            host_req    [N];
    logic            host_gnt    [N];
    logic [AW-1:0]   host_addr   [N];
    logic            host_we     [N];
    logic [DW/8-1:0] host_be     [N];
    logic [DW-1:0]   host_wdata  [N];
    logic            host_rvalid [N];
    logic [DW-1:0]   host_rdata  [N];
    logic            host_err    [N];
    logic            dev_req;
    logic [AW-1:0]   dev_addr;
    logic            dev_we;
    logic [DW/8-1:0] dev_be;
    logic [DW-1:0]   dev_wdata;
    logic            dev_rvalid;
    logic [DW-1:0]   dev_rdata;
    logic            dev_err;

    logic [N-1:0]    gnt_v, rvalid_v, err_v;

    int n_assert = 0;
    int n_fail   = 0;

    bus_rr_arbiter #(
        .NrHosts(N), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(16)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .host_req_i    (host_req),
        .host_gnt_o    (host_gnt),
        .host_addr_i   (host_addr),
        .host_we_i     (host_we),
        .host_be_i     (host_be),
        .host_wdata_i  (host_wdata),
        .host_rvalid_o (host_rvalid),
        .host_rdata_o  (host_rdata),
        .host_err_o    (host_err),
        .dev_req_o     (dev_req),
        .dev_addr_o    (dev_addr),
        .dev_we_o      (dev_we),
        .dev_be_o      (dev_be),
        .dev_wdata_o   (dev_wdata),
        .dev_rvalid_i  (dev_rvalid),
        .dev_rdata_i   (dev_rdata),
        .dev_err_i     (dev_err)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        gnt_v    = '0;
        rvalid_v = '0;
        err_v    = '0;
        for (int i = 0; i < N; i++) begin
            gnt_v[i]    = host_gnt[i];
            rvalid_v[i] = host_rvalid[i];
            err_v[i]    = host_err[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni     = 1'b0;
        dev_rvalid = 1'b0;
        dev_rdata  = '0;
        dev_err    = 1'b0;
        for (int i = 0; i < N; i++) begin
            host_req[i]   = 1'b1;
            host_addr[i]  = 32'h1000 + 32'(i * 16);
            host_we[i]    = 1'b0;
            host_be[i]    = 4'h3;
            host_wdata[i] = 32'hA000_0000 + 32'(i);
        end
        #1;
        chk("rst_gnt", 64'(gnt_v), 64'h0);
        chk("rst_dev_req", 64'(dev_req), 64'h0);
        chk("rst_dev_addr", 64'(dev_addr), 64'h0);
        chk("rst_dev_wdata", 64'(dev_wdata), 64'h0);
        tick();
        tick();
        rst_ni = 1'b1;

        // Round-robin order 0,1,2,0,1,2 with the device answering one cycle after the grant
        for (int g = 0; g < 6; g++) begin
            #1;
            chk("rr_gnt", 64'(gnt_v), 64'(3'b001 << (g % 3)));
            chk("rr_addr", 64'(dev_addr), 64'(32'h1000 + 32'((g % 3) * 16)));
            tick();
            dev_rvalid = 1'b1;
            dev_rdata  = 32'h5000 + 32'(g);
            #1;
            chk("rr_rvalid", 64'(rvalid_v), 64'(3'b001 << (g % 3)));
            chk("rr_rdata", 64'(host_rdata[g % 3]), 64'(32'h5000 + 32'(g)));
            chk("rr_nogrant_on_rsp", 64'(gnt_v), 64'h0);
            tick();
            dev_rvalid = 1'b0;
        end

        // Host 1 write: addr 0x100, data 0xDEADBEEF, be 0xF
        host_req[0]   = 1'b0;
        host_req[2]   = 1'b0;
        host_req[1]   = 1'b1;
        host_we[1]    = 1'b1;
        host_addr[1]  = 32'h100;
        host_wdata[1] = 32'hDEAD_BEEF;
        host_be[1]    = 4'hF;
        #1;
        chk("wr_gnt", 64'(gnt_v), 64'h2);
        chk("wr_dev_req", 64'(dev_req), 64'h1);
        chk("wr_addr", 64'(dev_addr), 64'h100);
        chk("wr_wdata", 64'(dev_wdata), 64'hDEAD_BEEF);
        chk("wr_be", 64'(dev_be), 64'hF);
        chk("wr_we", 64'(dev_we), 64'h1);
        tick();
        host_req[1] = 1'b0;
        #1;
        chk("wait_dev_req", 64'(dev_req), 64'h0);
        chk("wait_dev_addr", 64'(dev_addr), 64'h0);
        chk("wait_no_rvalid", 64'(rvalid_v), 64'h0);
        dev_rvalid = 1'b1;
        dev_rdata  = 32'h0;
        #1;
        chk("wr_rvalid", 64'(rvalid_v), 64'h2);
        chk("wr_err", 64'(err_v), 64'h0);
        tick();
        dev_rvalid = 1'b0;
        #1;
        chk("wr_rvalid_once", 64'(rvalid_v), 64'h0);

        // Silent device: timeout 16 cycles after the grant to host 0
        host_req[0] = 1'b1;
        #1;
        chk("to_gnt", 64'(gnt_v), 64'h1);
        tick();
        host_req[0] = 1'b0;
        for (int k = 1; k < 16; k++) begin
            #1;
            chk("to_early", 64'(rvalid_v), 64'h0);
            tick();
        end
        #1;
        chk("to_rvalid", 64'(rvalid_v), 64'h1);
        chk("to_err", 64'(err_v), 64'h1);
        chk("to_rdata", 64'(host_rdata[0]), 64'h0);
        tick();
        dev_rvalid = 1'b1;
        dev_rdata  = 32'h55;
        #1;
        chk("late_dropped", 64'(rvalid_v), 64'h0);
        chk("late_rdata", 64'(host_rdata[0]), 64'h0);
        tick();
        dev_rvalid = 1'b0;

        // Response with error on the exact timeout cycle (host 2)
        host_req[2] = 1'b1;
        #1;
        chk("co_gnt", 64'(gnt_v), 64'h4);
        tick();
        host_req[2] = 1'b0;
        for (int k = 1; k < 16; k++) tick();
        dev_rvalid = 1'b1;
        dev_err    = 1'b1;
        dev_rdata  = 32'hCAFE_0001;
        #1;
        chk("co_rvalid", 64'(rvalid_v), 64'h4);
        chk("co_err", 64'(err_v), 64'h4);
        chk("co_rdata", 64'(host_rdata[2]), 64'hCAFE_0001);
        tick();
        dev_rvalid = 1'b0;
        dev_err    = 1'b0;
        #1;
        chk("co_single", 64'(rvalid_v), 64'h0);
        chk("co_idle", 64'(gnt_v), 64'h0);

        // Wrap-around: only host 2 requests after last_q = 2
        host_req[2] = 1'b1;
        #1;
        chk("wrap_gnt", 64'(gnt_v), 64'h4);
        tick();
        dev_rvalid = 1'b1;
        #1;
        chk("wrap_rvalid", 64'(rvalid_v), 64'h4);
        chk("wrap_no_gnt_rsp", 64'(gnt_v), 64'h0);
        tick();
        dev_rvalid = 1'b0;
        #1;
        chk("wrap_regrant", 64'(gnt_v), 64'h4);
        tick();

        // Reset while in WAIT_RSP
        host_req[0] = 1'b1;
        #1;
        chk("hold_off", 64'(gnt_v), 64'h0);
        rst_ni     = 1'b0;
        dev_rvalid = 1'b1;
        dev_rdata  = 32'h77;
        #1;
        chk("arst_gnt", 64'(gnt_v), 64'h0);
        chk("arst_rvalid", 64'(rvalid_v), 64'h0);
        chk("arst_rdata", 64'(host_rdata[2]), 64'h0);
        chk("arst_err", 64'(err_v), 64'h0);
        chk("arst_dev_req", 64'(dev_req), 64'h0);
        tick();
        tick();
        rst_ni = 1'b1;
        #1;
        chk("post_rst_gnt", 64'(gnt_v), 64'h1);
        chk("post_rst_no_rsp", 64'(rvalid_v), 64'h0);
        tick();
        dev_rvalid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
